// File: rtl/microsequencer_if.sv
// Control-unit sequencing bus: microinstruction address control and opcode in,
// registered control state, retirement pulse, error flag and counters out.
interface microsequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic [1:0]       addrctl;
    logic [5:0]       opcode;
    logic [3:0]       state;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output en, addrctl, opcode,
        input  state, instr_done, illegal, instr_count, cycle_count
    );

    modport slave (
        input  en, addrctl, opcode,
        output state, instr_done, illegal, instr_count, cycle_count
    );
endinterface

// File: rtl/microsequencer.sv
// Next-state engine for the multicycle MIPS control unit: holds the control
// state register, decodes address control / dispatch, flags errors, counts.
module microsequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [3:0]  FETCH_ST = 4'd0
) (
    input  logic             clk,
    input  logic             reset,
    microsequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9
    } state_e;

    localparam logic [1:0] AC_SEQ   = 2'b00;
    localparam logic [1:0] AC_DISP1 = 2'b01;
    localparam logic [1:0] AC_DISP2 = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e           state_q, state_d;
    logic             instr_done_q, instr_done_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= state_e'(FETCH_ST);
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            instr_cnt_q  <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            instr_done_q <= instr_done_d;
            illegal_q    <= illegal_d;
            instr_cnt_q  <= instr_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    // Next-state decode; invalid current state overrides address control
    always_comb begin
        state_d      = state_q;
        instr_done_d = 1'b0;
        illegal_d    = illegal_q;
        instr_cnt_d  = instr_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;

        if (bus.en) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);

            if (state_q > JEX) begin
                state_d   = state_e'(FETCH_ST);
                illegal_d = 1'b1;
            end else begin
                unique case (bus.addrctl)
                    AC_SEQ: begin
                        // Sequencing past JEX would land on an invalid encoding
                        if (state_q == JEX) begin
                            state_d   = state_e'(FETCH_ST);
                            illegal_d = 1'b1;
                        end else begin
                            state_d = state_e'(state_q + 4'd1);
                        end
                    end
                    AC_DISP1: begin
                        unique case (bus.opcode)
                            OP_RTYPE:      state_d = RTYPEEX;
                            OP_LW, OP_SW:  state_d = MEMADR;
                            OP_BEQ:        state_d = BEQEX;
                            OP_J:          state_d = JEX;
                            default: begin
                                state_d   = state_e'(FETCH_ST);
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                    AC_DISP2: begin
                        unique case (bus.opcode)
                            OP_LW:   state_d = MEMRD;
                            OP_SW:   state_d = MEMWR;
                            default: begin
                                state_d   = state_e'(FETCH_ST);
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                    default: state_d = state_e'(FETCH_ST);
                endcase
            end

            // Any return to FETCH from elsewhere, error or not, retires
            if ((state_d == state_e'(FETCH_ST)) && (state_q != state_e'(FETCH_ST))) begin
                instr_done_d = 1'b1;
                instr_cnt_d  = instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.instr_done  = instr_done_q;
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = instr_cnt_q;
    assign bus.cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed vector bench for microsequencer, built with 4-bit counters so that
// counter wrap is reachable in a short run.
module tb_microsequencer;

    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic clk;
    logic reset;

    microsequencer_if #(.CNT_W(CNT_W)) bus ();

    microsequencer #(.CNT_W(CNT_W), .FETCH_ST(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] ac;
        logic [5:0] op;
        int         st;
        int         done;
        int         ill;
        int         icnt;
        int         ccnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(input logic e, input logic [1:0] a, input logic [5:0] o,
                               input int s, input int d, input int il, input int ic, input int cc);
        vec_t r;
        r.en = e; r.ac = a; r.op = o;
        r.st = s; r.done = d; r.ill = il; r.icnt = ic; r.ccnt = cc;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int s, input int d, input int il,
                             input int ic, input int cc);
        check({tag, ".state"},       int'(bus.state),       s);
        check({tag, ".instr_done"},  int'(bus.instr_done),  d);
        check({tag, ".illegal"},     int'(bus.illegal),     il);
        check({tag, ".instr_count"}, int'(bus.instr_count), ic);
        check({tag, ".cycle_count"}, int'(bus.cycle_count), cc);
    endtask

    // Drive inputs away from the edge, take one edge, settle
    task automatic step(input logic e, input logic [1:0] a, input logic [5:0] o);
        bus.en      = e;
        bus.addrctl = a;
        bus.opcode  = o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.addrctl = 2'b00;
        bus.opcode  = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // lw, sw, R-type, beq, j back to back; cycle_count wraps 15 -> 0
        vecs.push_back(v(1, 2'b00, OP_LW, 1, 0, 0, 0, 1));
        vecs.push_back(v(1, 2'b01, OP_LW, 2, 0, 0, 0, 2));
        vecs.push_back(v(1, 2'b10, OP_LW, 3, 0, 0, 0, 3));
        vecs.push_back(v(1, 2'b00, OP_LW, 4, 0, 0, 0, 4));
        vecs.push_back(v(1, 2'b11, OP_LW, 0, 1, 0, 1, 5));
        vecs.push_back(v(1, 2'b00, OP_SW, 1, 0, 0, 1, 6));
        vecs.push_back(v(1, 2'b01, OP_SW, 2, 0, 0, 1, 7));
        vecs.push_back(v(1, 2'b10, OP_SW, 5, 0, 0, 1, 8));
        vecs.push_back(v(1, 2'b11, OP_SW, 0, 1, 0, 2, 9));
        vecs.push_back(v(1, 2'b00, OP_R,  1, 0, 0, 2, 10));
        vecs.push_back(v(1, 2'b01, OP_R,  6, 0, 0, 2, 11));
        vecs.push_back(v(1, 2'b00, OP_R,  7, 0, 0, 2, 12));
        vecs.push_back(v(1, 2'b11, OP_R,  0, 1, 0, 3, 13));
        vecs.push_back(v(1, 2'b00, OP_BEQ, 1, 0, 0, 3, 14));
        vecs.push_back(v(1, 2'b01, OP_BEQ, 8, 0, 0, 3, 15));
        vecs.push_back(v(1, 2'b11, OP_BEQ, 0, 1, 0, 4, 0));
        vecs.push_back(v(1, 2'b00, OP_J,  1, 0, 0, 4, 1));
        vecs.push_back(v(1, 2'b01, OP_J,  9, 0, 0, 4, 2));
        vecs.push_back(v(1, 2'b11, OP_J,  0, 1, 0, 5, 3));
        // FETCH -> FETCH does not retire; en=0 ignores inputs
        vecs.push_back(v(1, 2'b11, OP_J,  0, 0, 0, 5, 4));
        vecs.push_back(v(0, 2'b00, OP_J,  0, 0, 0, 5, 4));
        // illegal opcode at DECODE, flag sticks through the following lw
        vecs.push_back(v(1, 2'b00, OP_BAD, 1, 0, 0, 5, 5));
        vecs.push_back(v(1, 2'b01, OP_BAD, 0, 1, 1, 6, 6));
        vecs.push_back(v(1, 2'b00, OP_LW, 1, 0, 1, 6, 7));
        vecs.push_back(v(1, 2'b01, OP_LW, 2, 0, 1, 6, 8));
        vecs.push_back(v(1, 2'b10, OP_LW, 3, 0, 1, 6, 9));
        vecs.push_back(v(1, 2'b00, OP_LW, 4, 0, 1, 6, 10));
        vecs.push_back(v(1, 2'b11, OP_LW, 0, 1, 1, 7, 11));
        // retirement pulse suppressed when the next cycle is not enabled
        vecs.push_back(v(0, 2'b00, OP_LW, 0, 0, 1, 7, 11));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].ac, vecs[i].op);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].done, vecs[i].ill,
                      vecs[i].icnt, vecs[i].ccnt);
        end

        // addrctl=00 in JEX is an error return
        do_reset();
        step(1, 2'b00, OP_J);
        step(1, 2'b01, OP_J);
        check_all("jex_pre", 9, 0, 0, 0, 2);
        step(1, 2'b00, OP_J);
        check_all("jex_seq", 0, 1, 1, 1, 3);

        // dispatch 2 with a non-memory opcode is an error return
        do_reset();
        step(1, 2'b00, OP_LW);
        step(1, 2'b01, OP_LW);
        step(1, 2'b10, OP_BEQ);
        check_all("disp2_bad", 0, 1, 1, 1, 3);

        // en=0 held three cycles in MEMRD
        do_reset();
        step(1, 2'b00, OP_LW);
        step(1, 2'b01, OP_LW);
        step(1, 2'b10, OP_LW);
        check_all("memrd", 3, 0, 0, 0, 3);
        for (int k = 0; k < 3; k++) begin
            step(0, 2'b11, OP_BAD);
            check_all($sformatf("hold%0d", k), 3, 0, 0, 0, 3);
        end
        step(1, 2'b00, OP_LW);
        check_all("resume", 4, 0, 0, 0, 4);

        // asynchronous reset mid-cycle while in RTYPEEX, with illegal set
        do_reset();
        step(1, 2'b00, OP_BAD);
        step(1, 2'b01, OP_BAD);
        step(1, 2'b00, OP_R);
        step(1, 2'b01, OP_R);
        check_all("rtypeex", 6, 0, 1, 1, 4);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0);
        bus.en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // 16 enabled cycles wrap the 4-bit cycle counter back to 0
        for (int k = 0; k < 15; k++) step(1, 2'b11, OP_R);
        check_all("wrap15", 0, 0, 0, 0, 15);
        step(1, 2'b11, OP_R);
        check_all("wrap16", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
